rom_scan_ctrl: RTL
==================

ROM_SCAN_CTRL -- requirements
Module: rom_scan_ctrl

Interface
REQ-001 The block SHALL have parameter EXPECT, default 16'hABCD: expected 16-bit ROM contents, bit n = ROM word at address n.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15: address-settle cycles inserted before each sample.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port start  input  1: scan request, sampled only in IDLE.
REQ-006 Port addr  output  4: address driven to the downstream 16x1 ROM.
REQ-007 Port rom_d  input  1: ROM read data, combinational function of addr.
REQ-008 Port busy  output  1: high from the cycle after an accepted start until the cycle before done.
REQ-009 Port done  output  1: one-cycle pulse marking scan completion.
REQ-010 Port word  output  16: captured ROM contents, bit n = rom_d sampled at addr = n.
REQ-011 Port match  output  1: word == EXPECT, valid from done until the next accepted start.

Function
REQ-012 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE with start=1: addr <= 0, word <= 0, match <= 0, settle counter <= 0; next state SETTLE if WAIT_CYCLES > 0, else SAMPLE.
REQ-014 IDLE with start=0: all outputs held; addr holds its last value.
REQ-015 SETTLE: stay exactly WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1), then go to SAMPLE; addr stable.
REQ-016 SAMPLE: word[addr] <= rom_d; if addr == 15 go to DONE, else addr <= addr + 1 and go to SETTLE (or SAMPLE again if WAIT_CYCLES = 0).
REQ-017 addr SHALL NOT wrap past 15 during a scan; after completion it holds 15 until the next start.
REQ-018 Each bit costs WAIT_CYCLES+1 cycles; done SHALL go high 16*(WAIT_CYCLES+1)+1 cycles after the edge that accepts start (33 cycles at default).
REQ-019 DONE: done = 1 for exactly one cycle, then IDLE; word holds until the next accepted start.
REQ-020 busy SHALL be high in SETTLE and SAMPLE only; done and busy are never both high.
REQ-021 start while not in IDLE (including DONE) SHALL be ignored and not queued.
REQ-022 start held high continuously SHALL launch back-to-back scans, with each new scan accepted in the IDLE cycle after done.
REQ-023 Only bit addr of word is written per SAMPLE; other bits are unchanged.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, addr = 0, word = 0, busy = 0, done = 0, match = 0, settle counter = 0.
REQ-025 rst asserted mid-scan SHALL abort the scan with no done pulse; the first start after release begins a fresh scan at addr 0.

Configuration
REQ-026 With macro ROM_SCAN_COMPARE_EN defined, match SHALL be registered in the DONE transition as (final word == EXPECT) and held until the next accepted start or reset.
REQ-027 Without ROM_SCAN_COMPARE_EN, match SHALL be constant 0, with no comparator logic; all other behaviour is identical.

Verification
REQ-028 ROM model INIT 16'hABCD, WAIT_CYCLES=1, start pulse -> addr steps 0..15, done at cycle 33, word = 16'hABCD, match = 1 (macro on).
REQ-029 ROM INIT 16'h1234, EXPECT default, macro on -> word = 16'h1234, match = 0; macro off -> match = 0.
REQ-030 WAIT_CYCLES=0, INIT 16'h8001 -> done at cycle 17, word = 16'h8001, busy high for 16 cycles.
REQ-031 rst pulsed at cycle 10 of a scan -> no done, word = 0, addr = 0; a following start yields the full correct word.
REQ-032 start held high for 80 cycles at default -> two completed scans, done pulses 34 cycles apart, mid-scan start ignored.

Source files
------------

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: walks a 16x1 combinational ROM from address 0 to 15 and
// captures every bit into a 16-bit word. WAIT_CYCLES address-settle cycles
// precede each sample. busy covers the scan, and done is a one-cycle pulse
// at completion.
// Optional feature: define ROM_SCAN_COMPARE_EN to register match as
// (captured word == EXPECT) when the scan completes. Without that macro,
// match is tied to 0 and no comparator is built.
module rom_scan_ctrl #(
  parameter logic [15:0] EXPECT      = 16'hABCD,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  addr,
  input  logic        rom_d,
  output logic        busy,
  output logic        done,
  output logic [15:0] word,
  output logic        match
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // With WAIT_CYCLES = 0 the SETTLE state is never entered.
  localparam bit         HAS_SETTLE  = (WAIT_CYCLES > 0);
  localparam logic [3:0] SETTLE_LAST = HAS_SETTLE ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  addr_reg, addr_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] word_reg, word_next;
  logic [15:0] bit_sel;
  logic        clear_match;
  logic        load_match;

  // One-hot decode of the current address. Only the selected bit of word
  // is rewritten in SAMPLE.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (addr_reg == 4'(gi));
    end
  endgenerate

  // Next-state and output decode. All defaults hold the current state.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    word_next   = word_reg;
    busy        = 1'b0;
    done        = 1'b0;
    clear_match = 1'b0;
    load_match  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next   = 4'd0;
          word_next   = 16'd0;
          cnt_next    = 4'd0;
          clear_match = 1'b1;
          state_next  = HAS_SETTLE ? SETTLE : SAMPLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = 4'd0;
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      SAMPLE: begin
        busy      = 1'b1;
        word_next = rom_d ? (word_reg | bit_sel) : (word_reg & ~bit_sel);
        if (addr_reg == 4'd15) begin
          // Leave addr at 15 so it does not wrap after the last bit.
          load_match = 1'b1;
          state_next = DONE;
        end else begin
          addr_next  = addr_reg + 4'd1;
          state_next = HAS_SETTLE ? SETTLE : SAMPLE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= 4'd0;
      cnt_reg   <= 4'd0;
      word_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
    end
  end

  assign addr = addr_reg;
  assign word = word_reg;

`ifdef ROM_SCAN_COMPARE_EN
  logic match_reg, match_next;

  // Compare the final word, including the bit captured on the last edge.
  always_comb begin
    match_next = match_reg;
    if (clear_match) begin
      match_next = 1'b0;
    end else if (load_match) begin
      match_next = (word_next == EXPECT);
    end
  end

  // Hold the compare result until the next accepted start or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_reg <= 1'b0;
    end else begin
      match_reg <= match_next;
    end
  end

  assign match = match_reg;
`else
  // No comparator is built, so match is tied low. The reduction below only
  // consumes otherwise-unused terms and generates no logic.
  logic unused_cfg;
  assign unused_cfg = ^{EXPECT, load_match, clear_match};
  assign match = 1'b0;
`endif

endmodule
